// File: rtl/approx_addsub_pipe_if.sv
// Stream interface for the approximate adder/subtractor: operand beat
// with per-beat configuration on the input side, result on the output side.
interface approx_addsub_pipe_if #(
  parameter int W       = 16,
  parameter int LPL_MAX = 8
);
  localparam int LW = $clog2(LPL_MAX + 1);

  logic          in_valid;
  logic          in_ready;
  logic          add_sub;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [LW-1:0] cfg_lpl;
  logic          cfg_exact;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    res;

  modport master (
    output in_valid, add_sub, in1, in2, cfg_lpl, cfg_exact, out_ready,
    input  in_ready, out_valid, res
  );

  modport slave (
    input  in_valid, add_sub, in1, in2, cfg_lpl, cfg_exact, out_ready,
    output in_ready, out_valid, res
  );
endinterface

// File: rtl/approx_addsub_pipe.sv
// Two-stage pipelined Lower-part-OR approximate adder/subtractor with a
// runtime-selectable lower-part length, exact bypass and an error monitor
// counting delivered results and results that differ from the exact sum.
// The bus interface must be instantiated with the same W and LPL_MAX.
module approx_addsub_pipe #(
  parameter int W       = 16,
  parameter int LPL_MAX = 8,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_addsub_pipe_if.slave  bus,
  input  logic                 cnt_clr,
  output logic [CW-1:0]        op_cnt,
  output logic [CW-1:0]        err_cnt
);
  localparam int LW = $clog2(LPL_MAX + 1);
  localparam logic [LW-1:0] LMAX = LW'(LPL_MAX);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic          v1, v2;
  logic          adv1, adv2;
  logic [W-1:0]  a1, b1, lo1;
  logic [LW-1:0] l1;
  logic          c1;
  logic [W:0]    res2, exact2;

  logic [W-1:0]  b_in, lo_mask, lo_in;
  logic [LW-1:0] l_in;
  logic          c_in;
  logic [W:0]    hi_sum, exact_sum, res_next;
  logic          deliver;

  assign adv2          = !v2 || bus.out_ready;
  assign adv1          = !v1 || adv2;
  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2;
  assign bus.res       = res2;
  assign deliver       = v2 && bus.out_ready;

  // Form operands, clamp the lower-part length and build the OR'd lower part and its carry.
  always_comb begin
    b_in = bus.add_sub ? (~bus.in2 + W'(1)) : bus.in2;
    if (bus.cfg_exact) begin
      l_in = '0;
    end else if (bus.cfg_lpl > LMAX) begin
      l_in = LMAX;
    end else begin
      l_in = bus.cfg_lpl;
    end
    lo_mask = ~({W{1'b1}} << l_in);
    lo_in   = (bus.in1 | b_in) & lo_mask;
    // mask ^ (mask >> 1) isolates bit L-1, and is zero when L is zero
    c_in    = |(bus.in1 & b_in & (lo_mask ^ (lo_mask >> 1)));
  end

  // Stage 1 register: captures an accepted beat, or a bubble, whenever it may advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      l1  <= '0;
      lo1 <= '0;
      c1  <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        a1  <= bus.in1;
        b1  <= b_in;
        l1  <= l_in;
        lo1 <= lo_in;
        c1  <= c_in;
      end
    end
  end

  // Upper-part sum with the injected carry, merged with the lower OR part; L=0 degenerates to the exact sum.
  always_comb begin
    exact_sum = {1'b0, a1} + {1'b0, b1};
    hi_sum    = ({1'b0, a1} >> l1) + ({1'b0, b1} >> l1) + (W+1)'(c1);
    res_next  = (hi_sum << l1) | {1'b0, lo1};
  end

  // Stage 2 register: holds the result stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      res2   <= '0;
      exact2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        res2   <= res_next;
        exact2 <= exact_sum;
      end
    end
  end

  // Saturating delivery and error counters; clear wins over a same-cycle delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (deliver) begin
      if (op_cnt != CMAX) begin
        op_cnt <= op_cnt + CW'(1);
      end
      if ((res2 != exact2) && (err_cnt != CMAX)) begin
        err_cnt <= err_cnt + CW'(1);
      end
    end
  end
endmodule

// File: doc/approx_addsub_pipe.md
Name: approx_addsub_pipe

Overview:
- Pipelined, parametrised approximate adder/subtractor with a valid/ready stream interface.
- Approximation is a Lower-part-OR Adder (LOA) whose lower-part length is selected at runtime per transaction. It is not fixed at elaboration.
- An exact-bypass mode and an on-line error monitor are built in. The monitor counts delivered results and results that differ from the exact sum.
- Drop-in datapath block for FPU significand/exponent adders during accuracy/energy exploration.

Parameters:
W, 16, operand width; result is W+1 bits.
LPL_MAX, 8, maximum lower-part length; must satisfy LPL_MAX < W.
CW, 16, width of op_cnt and err_cnt.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
add_sub  in  1  0 = in1+in2, 1 = in1-in2.
in1  in  W  operand A.
in2  in  W  operand B.
cfg_lpl  in  clog2(LPL_MAX+1)  lower-part length for this beat.
cfg_exact  in  1  1 = exact result for this beat.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
res  out  W+1  result.
cnt_clr  in  1  synchronous clear of both counters.
op_cnt  out  CW  delivered results, saturating.
err_cnt  out  CW  delivered results with res != exact, saturating.

Behaviour:
- Reset is asynchronous on rst_n low. out_valid, the internal stage valids, res, op_cnt and err_cnt all go to 0.
- A beat that is in flight when reset asserts is discarded.
- A beat is accepted when in_valid && in_ready.
- add_sub, cfg_lpl and cfg_exact are sampled with the operands on acceptance. A config change never affects beats already in flight.
- Operand forming: b = add_sub ? (-in2 mod 2^W) : in2. a = in1.
- Exact sum: E = a + b as a (W+1)-bit zero-extended sum; E[W] is the carry-out.
- Effective length L = cfg_exact ? 0 : min(cfg_lpl, LPL_MAX).
- LOA result for L > 0:
  - res[L-1:0] = a[L-1:0] | b[L-1:0].
  - c = a[L-1] & b[L-1].
  - res[W:L] = a[W-1:L] + b[W-1:L] + c, computed (W-L+1) bits wide.
- For L = 0, res = E.
- Stage 1 (S1) registers a, b, L, the lower OR result and c.
- Stage 2 (S2) registers the upper sum and E, and drives res/out_valid.
- Latency is 2 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Handshake:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1, a combinational function of state and out_ready.
  - No beat is dropped or duplicated; order is preserved.
  - res and out_valid hold stable while out_valid && !out_ready.
- Monitor, evaluated on delivery (out_valid && out_ready):
  - op_cnt increments by 1.
  - err_cnt increments by 1 if res != E.
  - Both counters saturate at 2^CW-1.
- cnt_clr has priority: both counters go to 0 on the next edge, and a delivery in the same cycle is not counted.
- in_valid low leaves the pipeline draining normally. Bubbles propagate as v=0.

Test Plan:
- LOA error case: W=16, L=4, add, in1=0x000F, in2=0x0001 → res=0x0000F two cycles after acceptance (exact 0x00010); op_cnt=1, err_cnt=1.
- LOA carry case: L=4, add, in1=0x0008, in2=0x0008 → lower 0x8, c=1, res=0x00018; err_cnt increments.
- Subtract, exact path: cfg_exact=1 (and separately cfg_lpl=0), sub, in1=0x0005, in2=0x0003 → b=0xFFFD, res=0x10002; err_cnt unchanged, op_cnt increments.
- Clamp: cfg_lpl=12 with LPL_MAX=8, in1=0x00FF, in2=0x0001 → L=8, res=0x000FF.
- Backpressure: stream 6 beats with out_ready=0 for cycles 2-5:
  - in_ready drops once S1 and S2 are full (2 beats held).
  - res stays stable while stalled.
  - All 6 results exit in order after out_ready=1, with no gaps once flowing.
- Reset and clear:
  - rst_n low while 2 beats are in flight → out_valid=0 immediately, counters 0, no stale result after release.
  - cnt_clr coincident with a delivery → counters 0.
  - With CW=4, 20 error deliveries → err_cnt=15 and op_cnt=15 (saturated).
